seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
//   Parametrised serial sequence detector: successor to the fixed-pattern seq_detect.
//   Samples one bit per enabled clock from a serial line. Pulses flag when the last
//   PAT_W sampled bits equal PATTERN. Supports overlapping and non-overlapping match
//   modes, plus a saturating match counter. Sits after the serial bit source in the
//   final-project datapath.
// PARAMETERS
//   PAT_W    5         pattern length in bits (>=2)
//   PATTERN  5'b10010  target sequence; MSB = oldest bit, LSB = newest bit
//   OVERLAP  1         1: a match's tail bits may start the next match; 0: restart after match
//   CNT_W    8         width of match counter
// PORTS
//   clk        in   1      clock, rising-edge active
//   rst        in   1      synchronous reset, active-high
//   en         in   1      bit-valid strobe; din is sampled only when en=1
//   din        in   1      serial data bit
//   cnt_clr    in   1      synchronous clear of match_cnt
//   flag       out  1      registered one-cycle match pulse
//   match_cnt  out  CNT_W  number of matches since reset/clear, saturating
//   cnt_sat    out  1      match_cnt is all ones
// BEHAVIOUR
//   - State: hist[PAT_W-1:0] shift reg, fill[log2(PAT_W+1)] valid-bit count, flag reg, match_cnt reg.
//   - rst=1 at edge: hist=0, fill=0, flag=0, match_cnt=0, cnt_sat=0. rst overrides every other input.
//   - en=1 at edge: hist_n={hist[PAT_W-2:0],din}; fill_n=min(fill+1,PAT_W).
//   - match = en && fill_n==PAT_W && hist_n==PATTERN. Bits present before reset never count.
//   - flag <= match. Latency: flag is high for the cycle after the edge that sampled
//     the final pattern bit. flag=0 in every other cycle, including all en=0 cycles.
//   - On match with OVERLAP=0: fill<=0, so the next match needs PAT_W fresh bits.
//     With OVERLAP=1: fill stays at PAT_W.
//   - en=0: hist and fill hold. Gaps between enabled bits do not break a sequence.
//   - match_cnt: +1 per match, saturating at 2^CNT_W-1 with no wrap.
//     cnt_clr=1 forces 0, and a match in the same cycle is dropped from the count.
//     flag still pulses on that match.
//   - cnt_sat = &match_cnt, combinational from the register.
//   - din is ignored (X-tolerant) when en=0 or rst=1.
// TESTING
//   1 Defaults. Bits 1,0,0,1,0,0,1,0 with en=1 each cycle -> flag pulses after
//     bit 5 and after bit 8, match_cnt=2.
//   2 OVERLAP=0, same stream -> flag only after bit 5, match_cnt=1.
//   3 PATTERN=5'b00010. After rst, feed 1,0 -> no flag (fill=2).
//     Then 0,0,0,1,0 -> one flag after the last bit.
//   4 Defaults, en low for 3 cycles between every bit of 1,0,0,1,0 (din toggling
//     while en=0) -> single flag one cycle after the 5th enabled edge.
//   5 CNT_W=2: 5 matches -> match_cnt=3, cnt_sat=1.
//     cnt_clr coincident with a 6th match -> flag=1, match_cnt=0.
//   6 Reset mid-operation: feed 1,0,0,1, assert rst one cycle, then feed 0 -> no flag.
//     Then a full 1,0,0,1,0 -> flag, match_cnt=1.

Source files
------------

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector. One bit is shifted in per enabled clock,
// and flag pulses for one cycle whenever the last PAT_W valid bits equal PATTERN.
module seq_detect_param #(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10010,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             cnt_clr,
  output logic             flag,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int               FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [FILL_W-1:0] fill_inc;
  logic              flag_q, flag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              match;

  // NOTE: every variable gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    hist_d   = hist_q;
    fill_d   = fill_q;
    fill_inc = (fill_q == FULL) ? FULL : fill_q + 1'b1;
    match    = 1'b0;
    cnt_d    = cnt_q;

    if (en) begin
      hist_d = {hist_q[PAT_W-2:0], din};
      fill_d = fill_inc;
      match  = (fill_inc == FULL) && (hist_d == PATTERN);
      // Non-overlapping mode demands a full set of fresh bits after each hit.
      if (match && !OVERLAP) fill_d = '0;
    end

    flag_d = match;

    if (cnt_clr)                     cnt_d = '0;
    else if (match && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      flag_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign flag      = flag_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = &cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: four parameter variants share one stimulus
// stream, and each step compares outputs against hand-computed values.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst, en, din, cnt_clr;

  logic       flag_def, flag_novl, flag_pat, flag_cnt;
  logic [7:0] cnt_def, cnt_novl, cnt_pat;
  logic [1:0] cnt_cnt;
  logic       sat_def, sat_novl, sat_pat, sat_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_detect_param u_def (
    .clk(clk), .rst(rst), .en(en), .din(din), .cnt_clr(cnt_clr),
    .flag(flag_def), .match_cnt(cnt_def), .cnt_sat(sat_def));

  seq_detect_param #(.OVERLAP(1'b0)) u_novl (
    .clk(clk), .rst(rst), .en(en), .din(din), .cnt_clr(cnt_clr),
    .flag(flag_novl), .match_cnt(cnt_novl), .cnt_sat(sat_novl));

  seq_detect_param #(.PATTERN(5'b00010)) u_pat (
    .clk(clk), .rst(rst), .en(en), .din(din), .cnt_clr(cnt_clr),
    .flag(flag_pat), .match_cnt(cnt_pat), .cnt_sat(sat_pat));

  seq_detect_param #(.CNT_W(2)) u_cnt (
    .clk(clk), .rst(rst), .en(en), .din(din), .cnt_clr(cnt_clr),
    .flag(flag_cnt), .match_cnt(cnt_cnt), .cnt_sat(sat_cnt));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs set at the falling edge, outputs sampled 1 time unit after the rising edge.
  task automatic drive(input logic e, input logic d, input logic c);
    @(negedge clk);
    en = e; din = d; cnt_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; din = 1'bx; cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0; en = 1'b0; din = 1'b0;
  endtask

  initial begin
    logic s1 [8];
    logic e_def [8];
    logic e_novl [8];
    logic s3 [7];
    logic e3 [7];
    logic s4 [5];
    logic s6 [5];

    rst = 1'b1; en = 1'b0; din = 1'b0; cnt_clr = 1'b0;
    s1     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    e_def  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    e_novl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    s3     = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    e3     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    s4     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    s6     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    do_reset();
    check("rst_flag", flag_def, 0);
    check("rst_cnt", cnt_def, 0);
    check("rst_sat", sat_def, 0);
    check("rst_cnt_w2", cnt_cnt, 0);

    // Overlapping vs non-overlapping on the same stream
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, s1[i], 1'b0);
      check($sformatf("t1_flag_def[%0d]", i), flag_def, e_def[i]);
      check($sformatf("t2_flag_novl[%0d]", i), flag_novl, e_novl[i]);
    end
    check("t1_cnt_def", cnt_def, 2);
    check("t2_cnt_novl", cnt_novl, 1);
    drive(1'b0, 1'b1, 1'b0);
    check("t1_flag_idle", flag_def, 0);

    // Pattern 00010 present in hist right after reset must not fire before fill
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, s3[i], 1'b0);
      check($sformatf("t3_flag_pat[%0d]", i), flag_pat, e3[i]);
    end
    check("t3_cnt_pat", cnt_pat, 1);

    // en gaps with din toggling do not break the sequence
    do_reset();
    for (int i = 0; i < 5; i++) begin
      for (int g = 0; g < 3; g++) begin
        drive(1'b0, g[0], 1'b0);
        check($sformatf("t4_gap_flag[%0d.%0d]", i, g), flag_def, 0);
      end
      drive(1'b1, s4[i], 1'b0);
      check($sformatf("t4_flag[%0d]", i), flag_def, (i == 4) ? 1 : 0);
    end
    drive(1'b0, 1'b1, 1'b0);
    check("t4_flag_after", flag_def, 0);
    check("t4_cnt", cnt_def, 1);

    // Saturating 2-bit counter and cnt_clr coinciding with a match
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, s4[i], 1'b0);
    check("t5_cnt_m1", cnt_cnt, 1);
    for (int m = 2; m <= 5; m++) begin
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      check($sformatf("t5_flag_m%0d", m), flag_cnt, 1);
      check($sformatf("t5_cnt_m%0d", m), cnt_cnt, (m < 3) ? m : 3);
      check($sformatf("t5_sat_m%0d", m), sat_cnt, (m >= 3) ? 1 : 0);
    end
    check("t5_cnt_def5", cnt_def, 5);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    check("t5_clr_flag", flag_cnt, 1);
    check("t5_clr_cnt", cnt_cnt, 0);
    check("t5_clr_sat", sat_cnt, 0);
    check("t5_clr_cnt_def", cnt_def, 0);

    // Reset mid-sequence discards partial history
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, s6[i], 1'b0);
    do_reset();
    check("t6_rst_flag", flag_def, 0);
    drive(1'b1, 1'b0, 1'b0);
    check("t6_no_flag", flag_def, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, s6[i], 1'b0);
      check($sformatf("t6_flag[%0d]", i), flag_def, (i == 4) ? 1 : 0);
    end
    check("t6_cnt", cnt_def, 1);

    drive(1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
